// File: rtl/arith_pkg.sv
// Shared control definitions for the sequential multiply/divide units.
// Both datapaths use the same start/ready handshake and state encoding.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    DONE      = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {r,q} left, then subtract d if it fits.
module divider_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);

  logic [N:0]   r_sh;
  logic [N-1:0] q_sh;
  logic [N:0]   trial;

  // r stays below d, so its top bit is always zero and can be dropped by the shift
  assign r_sh  = {r[N-1:0], q[N-1]};
  assign q_sh  = {q[N-2:0], 1'b0};
  assign trial = r_sh - {1'b0, d};

  always_comb begin
    r_next = r_sh;
    q_next = q_sh;
    if (!trial[N]) begin
      r_next = trial;
      q_next = q_sh | {{(N-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
//   state     | meaning
//   IDLE      | waiting for start; operands captured on acceptance
//   COMPUTING | one restoring iteration per cycle, N cycles
//   DONE      | results registered, one-cycle ready pulse
module divider
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic          dbz;
  logic [N:0]    r_next;
  logic [N-1:0]  q_next;

  divider_step #(.N(N)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      dbz         <= 1'b0;
      ready       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q     <= dividend;
            d     <= divisor;
            r     <= '0;
            cnt   <= '0;
            dbz   <= (divisor == '0);
            state <= (divisor == '0) ? DONE : COMPUTING;
          end
        end
        COMPUTING: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= DONE;
        end
        DONE: begin
          // on divide-by-zero q still holds the untouched dividend
          quotient    <= dbz ? '1 : q;
          remainder   <= dbz ? q : r[N-1:0];
          div_by_zero <= dbz;
          ready       <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus a shuffled sweep of all operand pairs.
module tb_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // edges counted from the current time until ready is seen; -1 on timeout
  task automatic wait_ready(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (ready) begin
        cyc = k;
        break;
      end
    end
  endtask

  function automatic int exp_q(input int a, input int b);
    return (b == 0) ? (1 << N) - 1 : a / b;
  endfunction

  function automatic int exp_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int exp_lat(input int b);
    return (b == 0) ? 1 : N + 1;
  endfunction

  task automatic check_result(input string tag, input int a, input int b);
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q(a, b)));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r(a, b)));
    check({tag, " dbz"}, 32'(div_by_zero), 32'(b == 0));
  endtask

  task automatic run_op(input string tag, input int a, input int b);
    int cyc;
    @(negedge clk);
    dividend = N'(a);
    divisor  = N'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready(cyc);
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat(b)));
    check_result(tag, a, b);
    @(posedge clk); #1;
    check({tag, " ready pulse width"}, 32'(ready), 32'(0));
    check({tag, " quotient hold"}, 32'(quotient), 32'(exp_q(a, b)));
  endtask

  initial begin
    int cyc;
    int n_rdy;
    int perm[256];

    repeat (2) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'(0));
    check("reset quotient", 32'(quotient), 32'(0));
    check("reset remainder", 32'(remainder), 32'(0));
    check("reset dbz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;

    run_op("13/3", 13, 3);
    run_op("15/1", 15, 1);
    run_op("0/5", 0, 5);
    run_op("5/7", 5, 7);
    run_op("15/15", 15, 15);
    run_op("7/0", 7, 0);
    run_op("9/2", 9, 2);

    // re-pulse start with new operands while computing: must be ignored
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd4;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_rdy = 0;
    cyc   = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin
        dividend = 4'd9;
        divisor  = 4'd3;
        start    = 1'b1;
      end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (ready) begin
        n_rdy++;
        if (cyc < 0) cyc = k;
        check_result("restart", 12, 4);
      end
    end
    check("restart ready count", 32'(n_rdy), 32'(1));
    check("restart latency", 32'(cyc), 32'(N + 1));

    // reset at iteration 2 aborts the operation
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort quotient", 32'(quotient), 32'(0));
    check("abort remainder", 32'(remainder), 32'(0));
    check("abort dbz", 32'(div_by_zero), 32'(0));
    n_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ready) n_rdy++;
    end
    check("abort ready count", 32'(n_rdy), 32'(0));
    run_op("10/3", 10, 3);

    // shuffled sweep of every operand pair with start held high
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    @(negedge clk);
    dividend = N'(perm[0] >> N);
    divisor  = N'(perm[0]);
    start    = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      a = perm[i] >> N;
      b = perm[i] & ((1 << N) - 1);
      if (i < 255) begin
        dividend = N'(perm[i + 1] >> N);
        divisor  = N'(perm[i + 1]);
      end else begin
        start = 1'b0;
      end
      wait_ready(cyc);
      check("sweep latency", 32'(cyc), 32'(exp_lat(b)));
      check_result("sweep", a, b);
      if (b != 0) begin
        check("sweep invariant", 32'(int'(quotient) * b + int'(remainder)), 32'(a));
        check("sweep rem<div", 32'(int'(remainder) < b), 32'(1));
      end
      if (i < 255) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("sweep final ready low", 32'(ready), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
